// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the display scan scheduler.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package display_sched_pkg;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        SHOW_ONES = 2'd0,
        BLANK_A   = 2'd1,
        SHOW_TENS = 2'd2,
        BLANK_B   = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

    // Any non-BCD code decodes to a dash; used to show "no channel" on both digits.
    localparam logic [3:0] DIGIT_DASH = 4'hA;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_scheduler_seg7_decode.sv
// Combinational BCD to 7-segment decoder with a blanking input.
// Codes 10-15 show a dash so corrupted digits are visibly wrong rather than random.
module seg7_decode
    import display_sched_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanking overrides everything; otherwise standard digit lookup.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-shares one 2-digit multiplexed 7-segment display among three countdown
// channels: ones/tens scan with blanking gaps, round-robin channel rotation,
// and alerting channels preempting the rotation.
// Optional feature macro: DISP_ALERT_BLINK_EN (alerting channel blinks with a
// 32-scan half period); when undefined the alerting channel is shown steadily.
module display_scan_scheduler
    import display_sched_pkg::*;
#(
    parameter int SHOW_CYC    = 1024,
    parameter int BLANK_CYC   = 16,
    parameter int DWELL_SCANS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [NUM_CH-1:0]     ch_alert,
    input  logic [4*NUM_CH-1:0]   ch_tens,
    input  logic [4*NUM_CH-1:0]   ch_ones,
    output logic [6:0]            seg_out,
    output logic                  dig_sel,
    output logic [1:0]            chan_idx,
    output logic                  scan_tick
);

    localparam int SLOT_MAX = max2(SHOW_CYC, BLANK_CYC);
    localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
    localparam int DWELL_W  = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;

    localparam logic [SLOT_W-1:0]  SHOW_LAST  = SLOT_W'(SHOW_CYC - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SCANS - 1);

    scan_state_t        state, next_state;
    logic [SLOT_W-1:0]  slot, next_slot;
    logic               slot_last, boundary;

    logic [DWELL_W-1:0] dwell, pick_dwell, nxt_dwell;
    logic               in_alert, nxt_alert, pick_alert, pick_none;
    logic [1:0]         pick_idx, nxt_idx, rot_1, rot_2;
    logic [3:0]         lat_ones, lat_tens, nxt_ones, nxt_tens;

    logic               show_tens, dec_blank, blink_blank;
    logic [3:0]         dec_digit;
    logic [6:0]         dec_seg;

    // Slot timing: advance the scan phase when the current slot's length is used up.
    always_comb begin
        slot_last  = (state == SHOW_ONES || state == SHOW_TENS) ? (slot == SHOW_LAST)
                                                                : (slot == BLANK_LAST);
        boundary   = (state == BLANK_B) && slot_last;
        next_state = state;
        next_slot  = slot + 1'b1;
        if (slot_last) begin
            next_slot = '0;
            case (state)
                SHOW_ONES: next_state = BLANK_A;
                BLANK_A:   next_state = SHOW_TENS;
                SHOW_TENS: next_state = BLANK_B;
                default:   next_state = SHOW_ONES;
            endcase
        end
    end

    // Channel choice for the next scan: alert first, then dwell, then rotation.
    always_comb begin
        rot_1      = (chan_idx == 2'd2) ? 2'd0 : chan_idx + 2'd1;
        rot_2      = (rot_1 == 2'd2) ? 2'd0 : rot_1 + 2'd1;
        pick_idx   = chan_idx;
        pick_dwell = '0;
        pick_alert = 1'b0;
        pick_none  = 1'b0;
        if (ch_alert[0]) begin
            pick_idx   = 2'd0;
            pick_alert = 1'b1;
        end else if (ch_alert[1]) begin
            pick_idx   = 2'd1;
            pick_alert = 1'b1;
        end else if (ch_alert[2]) begin
            pick_idx   = 2'd2;
            pick_alert = 1'b1;
        end else if (!in_alert && ch_valid[chan_idx] && dwell != DWELL_LAST) begin
            pick_dwell = dwell + 1'b1;
        end else if (ch_valid[rot_1]) begin
            pick_idx = rot_1;
        end else if (ch_valid[rot_2]) begin
            pick_idx = rot_2;
        end else if (ch_valid[chan_idx]) begin
            pick_idx = chan_idx;
        end else begin
            pick_none = 1'b1;
        end
    end

    // Latched scan data only changes at the scan boundary so a scan never tears.
    always_comb begin
        nxt_idx   = chan_idx;
        nxt_dwell = dwell;
        nxt_alert = in_alert;
        nxt_ones  = lat_ones;
        nxt_tens  = lat_tens;
        if (boundary) begin
            nxt_idx   = pick_idx;
            nxt_dwell = pick_dwell;
            nxt_alert = pick_alert;
            nxt_ones  = pick_none ? DIGIT_DASH : ch_ones[{pick_idx, 2'b00} +: 4];
            nxt_tens  = pick_none ? DIGIT_DASH : ch_tens[{pick_idx, 2'b00} +: 4];
        end
    end

`ifdef DISP_ALERT_BLINK_EN
    logic [5:0] blink_cnt, nxt_blink;

    // Blink phase counts alert scans, restarting whenever an alert is newly entered.
    always_comb begin
        nxt_blink = blink_cnt;
        if (boundary) begin
            nxt_blink = (pick_alert && in_alert) ? blink_cnt + 6'd1 : 6'd0;
        end
    end

    assign blink_blank = nxt_alert & nxt_blink[5];
`else
    assign blink_blank = 1'b0;
`endif

    // Select the digit for the upcoming slot; a zero tens digit is suppressed.
    always_comb begin
        show_tens = (next_state == SHOW_TENS);
        dec_digit = show_tens ? nxt_tens : nxt_ones;
        dec_blank = blink_blank || (show_tens && nxt_tens == 4'd0);
    end

    seg7_decode u_decode (
        .bcd   (dec_digit),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    // Scan FSM, latched channel data and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK_B;
            slot      <= '0;
            dwell     <= '0;
            in_alert  <= 1'b0;
            chan_idx  <= 2'd0;
            lat_ones  <= 4'd0;
            lat_tens  <= 4'd0;
            seg_out   <= SEG_BLANK;
            dig_sel   <= 1'b0;
            scan_tick <= 1'b0;
`ifdef DISP_ALERT_BLINK_EN
            blink_cnt <= 6'd0;
`endif
        end else begin
            state     <= next_state;
            slot      <= next_slot;
            dwell     <= nxt_dwell;
            in_alert  <= nxt_alert;
            chan_idx  <= nxt_idx;
            lat_ones  <= nxt_ones;
            lat_tens  <= nxt_tens;
            seg_out   <= (next_state == SHOW_ONES || next_state == SHOW_TENS) ? dec_seg : SEG_BLANK;
            dig_sel   <= (next_state == BLANK_A || next_state == SHOW_TENS);
            scan_tick <= (next_state == BLANK_B) && (next_slot == BLANK_LAST);
`ifdef DISP_ALERT_BLINK_EN
            blink_cnt <= nxt_blink;
`endif
        end
    end

endmodule
